// File: rtl/uart_fifo_peripheral.sv
// Memory-mapped UART: runtime baud divisor, 16x RX oversampling, TX/RX FIFOs,
// sticky error flags and a maskable interrupt on the CPU peripheral bus.
module uart_fifo_peripheral #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0040,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        PC_31,
    output logic        irqout,
    input  logic        rxd,
    output logic        txd
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [31:0] A_TXDATA  = BASE_ADDR;
    localparam logic [31:0] A_RXDATA  = BASE_ADDR + 32'h04;
    localparam logic [31:0] A_STATUS  = BASE_ADDR + 32'h08;
    localparam logic [31:0] A_CTRL    = BASE_ADDR + 32'h0C;
    localparam logic [31:0] A_BAUDDIV = BASE_ADDR + 32'h10;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic        sel_tx, sel_rx, sel_status, sel_ctrl, sel_baud;
    logic        wr_tx, wr_status, wr_ctrl, wr_baud, rd_rx;
    logic [3:0]  ctrl;
    logic [15:0] bauddiv, tick_cnt;
    logic        tick;

    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic        tx_push, tx_pop, rx_push, rx_pop;

    state_t      tx_state, rx_state;
    logic [3:0]  tx_tcnt, rx_tcnt;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_shreg, rx_shreg;
    logic        tx_busy, tx_bit_end;

    logic        rx_s1, rx_s2, rx_s3, rx_fall;
    logic        rx_done, rx_good, set_ferr, set_ovr;
    logic        frame_err, overrun;
    logic [6:0]  status;
    logic        unused_wdata;

    assign unused_wdata = ^wdata[31:16];

    assign sel_tx     = (addr == A_TXDATA);
    assign sel_rx     = (addr == A_RXDATA);
    assign sel_status = (addr == A_STATUS);
    assign sel_ctrl   = (addr == A_CTRL);
    assign sel_baud   = (addr == A_BAUDDIV);

    assign wr_tx      = wr & sel_tx;
    assign wr_status  = wr & sel_status;
    assign wr_ctrl    = wr & sel_ctrl;
    assign wr_baud    = wr & sel_baud;
    assign rd_rx      = rd & sel_rx;

    // Baud tick generator and configuration registers
    assign tick = (tick_cnt == bauddiv);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            bauddiv  <= DIV_RESET;
            ctrl     <= '0;
        end else begin
            if (wr_baud) begin
                bauddiv  <= wdata[15:0];
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 16'd1;
            end
            if (wr_ctrl)
                ctrl <= wdata[3:0];
        end
    end

    // FIFO flags; the extra pointer MSB distinguishes full from empty
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

    assign tx_push  = wr_tx & (~tx_full | tx_pop);
    assign rx_pop   = rd_rx & ~rx_empty;
    assign rx_push  = rx_good & (~rx_full | rx_pop);

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wp[AW-1:0]] <= wdata[7:0];
        if (rx_push)
            rx_mem[rx_wp[AW-1:0]] <= rx_shreg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
        end
    end

    // TX: frames start on a tick so every bit is exactly 16 ticks; a frame
    // may start straight out of STOP to avoid an idle gap between bytes.
    assign tx_busy    = (tx_state != S_IDLE);
    assign tx_bit_end = tick & (tx_tcnt == 4'd15);
    assign tx_pop     = tick & ctrl[0] & ~tx_empty &
                        ((tx_state == S_IDLE) | ((tx_state == S_STOP) & (tx_tcnt == 4'd15)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= S_IDLE;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            txd      <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= S_START;
            tx_shreg <= tx_mem[tx_rp[AW-1:0]];
            tx_tcnt  <= '0;
            txd      <= 1'b0;
        end else begin
            if (tick && tx_state != S_IDLE)
                tx_tcnt <= tx_tcnt + 4'd1;
            case (tx_state)
                S_IDLE: ;
                S_START:
                    if (tx_bit_end) begin
                        tx_state <= S_DATA;
                        tx_bit   <= '0;
                        txd      <= tx_shreg[0];
                    end
                S_DATA:
                    if (tx_bit_end) begin
                        if (tx_bit == 3'd7) begin
                            tx_state <= S_STOP;
                            txd      <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shreg <= tx_shreg >> 1;
                            txd      <= tx_shreg[1];
                        end
                    end
                S_STOP:
                    if (tx_bit_end)
                        tx_state <= S_IDLE;
            endcase
        end
    end

    // RX: synchronize, detect the start edge, then sample mid-bit
    assign rx_fall  = rx_s3 & ~rx_s2;
    assign rx_done  = (rx_state == S_STOP) & tick & (rx_tcnt == 4'd15);
    assign rx_good  = rx_done & rx_s2;
    assign set_ferr = rx_done & ~rx_s2;
    assign set_ovr  = rx_good & rx_full & ~rx_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= S_IDLE;
            rx_tcnt  <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            if (tick && rx_state != S_IDLE)
                rx_tcnt <= rx_tcnt + 4'd1;
            case (rx_state)
                S_IDLE:
                    if (ctrl[1] && rx_fall) begin
                        rx_state <= S_START;
                        rx_tcnt  <= '0;
                    end
                S_START:
                    if (tick && rx_tcnt == 4'd7) begin
                        rx_tcnt  <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    end
                S_DATA:
                    if (tick && rx_tcnt == 4'd15) begin
                        rx_shreg <= {rx_s2, rx_shreg[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7)
                            rx_state <= S_STOP;
                    end
                S_STOP:
                    if (rx_done)
                        rx_state <= S_IDLE;
            endcase
        end
    end

    // Sticky flags (a same-cycle set beats the W1C) and the registered IRQ
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            irqout    <= 1'b0;
        end else begin
            frame_err <= set_ferr | (frame_err & ~(wr_status & wdata[6]));
            overrun   <= set_ovr  | (overrun   & ~(wr_status & wdata[5]));
            irqout    <= ~PC_31 & ((ctrl[3] & ~rx_empty) | (ctrl[2] & tx_empty & ~tx_busy));
        end
    end

    assign status = {frame_err, overrun, tx_busy, rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_rx)
                rdata = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rp[AW-1:0]]};
            else if (sel_status)
                rdata = {25'h0, status};
            else if (sel_ctrl)
                rdata = {28'h0, ctrl};
            else if (sel_baud)
                rdata = {16'h0, bauddiv};
        end
    end

endmodule
